mem_responder: RTL and testbench

Memory-side responder for the byte-serial RAM bus driven by the load/store buffer. Each cycle it services one byte: a RAM write, a RAM read with one-cycle latency, or an access to a small memory-mapped I/O window. The I/O window backs a transmit FIFO, a receive FIFO, a status byte and a halt flag. It sits between the core's memory port and the top-level byte RAM / serial link, and drives the global stall used as the core's pause.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 96 +++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Byte-serial RAM bus from the load/store buffer plus the serial-link byte streams
// and halt flag served by mem_responder.
interface mem_responder_if;
   logic [31:0] ram_addr;
   logic        ram_writing;
   logic [7:0]  ram_data;
   logic [7:0]  ram_loaded_data;
   logic        io_stall;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        halted;

   modport master (
      output ram_addr, ram_writing, ram_data, tx_ready, rx_data, rx_valid,
      input  ram_loaded_data, io_stall, tx_data, tx_valid, rx_ready, halted
   );

   modport slave (
      input  ram_addr, ram_writing, ram_data, tx_ready, rx_data, rx_valid,
      output ram_loaded_data, io_stall, tx_data, tx_valid, rx_ready, halted
   );
endinterface

// File: rtl/mem_responder.sv
// One byte per cycle: RAM read/write with 1-cycle read latency, or an I/O window
// backing tx/rx FIFOs, a status byte and a sticky halt flag.
module mem_responder #(
   parameter int          ADDR_WIDTH = 17,
   parameter logic [31:0] IO_BASE    = 32'h0003_0000,
   parameter int          FIFO_DEPTH = 8
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [7:0]            mem    [2**ADDR_WIDTH];
   logic [7:0]            tx_mem [FIFO_DEPTH];
   logic [7:0]            rx_mem [FIFO_DEPTH];
   logic [PW-1:0]         tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0]         tx_cnt, rx_cnt;
   logic                  halted_q;
   logic [7:0]            rd_q, rd_next;

   logic [ADDR_WIDTH-1:0] idx;
   logic [2:0]            off;
   logic                  io_sel, io_wr, io_rd, ram_wr, ram_rd;
   logic                  tx_full, rx_nonempty, tx_pop, tx_push, rx_push, rx_pop, stall;

   assign idx         = bus.ram_addr[ADDR_WIDTH-1:0];
   assign off         = bus.ram_addr[2:0];
   assign io_sel      = bus.ram_addr[31:16] == IO_BASE[31:16];
   assign io_wr       = io_sel && bus.ram_writing;
   assign io_rd       = io_sel && !bus.ram_writing;
   assign ram_wr      = !io_sel && bus.ram_writing;
   assign ram_rd      = !io_sel && !bus.ram_writing;

   assign tx_full     = tx_cnt == FULL;
   assign rx_nonempty = rx_cnt != '0;
   assign tx_pop      = bus.tx_valid && bus.tx_ready;
   // A full tx FIFO still takes the push when the link drains its head this cycle.
   assign stall       = io_wr && off == 3'd0 && tx_full && !tx_pop;
   assign tx_push     = io_wr && off == 3'd0 && !stall;
   assign rx_push     = bus.rx_valid && bus.rx_ready;
   assign rx_pop      = io_rd && off == 3'd0 && rx_nonempty;

   assign bus.io_stall        = stall;
   assign bus.tx_valid        = tx_cnt != '0;
   assign bus.tx_data         = tx_mem[tx_rp];
   assign bus.rx_ready        = rx_cnt != FULL;
   assign bus.halted          = halted_q;
   assign bus.ram_loaded_data = rd_q;

   always_comb begin
      rd_next = 8'h00;
      if (ram_rd)
         rd_next = mem[idx];
      else if (io_rd && off == 3'd0 && rx_nonempty)
         rd_next = rx_mem[rx_rp];
      else if (io_rd && off == 3'd4)
         rd_next = {6'b0, tx_full, rx_nonempty};
   end

   // RAM contents survive reset; only the write is suppressed on a reset cycle.
   always_ff @(posedge clk)
      if (rst && ram_wr) mem[idx] <= bus.ram_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_cnt   <= '0;
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_cnt   <= '0;
         halted_q <= 1'b0;
         rd_q     <= 8'h00;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wp] <= bus.ram_data;
            tx_wp         <= tx_wp + 1'b1;
         end
         if (tx_pop) tx_rp <= tx_rp + 1'b1;
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);

         if (rx_push) begin
            rx_mem[rx_wp] <= bus.rx_data;
            rx_wp         <= rx_wp + 1'b1;
         end
         if (rx_pop) rx_rp <= rx_rp + 1'b1;
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);

         if (io_wr && off == 3'd4) halted_q <= 1'b1;
         rd_q <= rd_next;
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized traffic against a queue-based reference model; a negedge
// monitor compares per-cycle status, read data and link bytes against scoreboard queues.
module tb_mem_responder;
   localparam int          D   = 8;
   localparam logic [31:0] IOB = 32'h0003_0000;

   logic clk = 1'b0;
   logic rst;
   mem_responder_if bus();

   mem_responder #(.ADDR_WIDTH(17), .IO_BASE(IOB), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       stall;
      logic       txv;
      logic       rxr;
      logic       hlt;
      logic [7:0] txd;
   } st_t;

   st_t        st_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] link_q[$];

   logic [7:0] m_mem [int];
   logic [7:0] m_tx[$];
   logic [7:0] m_rx[$];
   bit         m_halt;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive inputs after the edge, then advance the reference model.
   task automatic step(input logic [31:0] a, input bit w, input logic [7:0] d,
                       input bit txr = 0, input bit rxv = 0, input logic [7:0] rxd = 0,
                       input bit r = 1);
      st_t        s;
      logic [7:0] rd;
      bit         io, stall, rx_can;
      logic [2:0] off;
      int         idx;
      @(posedge clk);
      #1;
      rst = r;
      bus.ram_addr = a;
      bus.ram_writing = w;
      bus.ram_data = d;
      bus.tx_ready = txr;
      bus.rx_valid = rxv;
      bus.rx_data = rxd;

      io     = a[31:16] == IOB[31:16];
      off    = a[2:0];
      idx    = int'(a[16:0]);
      stall  = io && w && off == 3'd0 && m_tx.size() == D && !(txr && m_tx.size() > 0);
      rx_can = m_rx.size() != D;
      s.stall = stall;
      s.txv   = m_tx.size() != 0;
      s.txd   = (m_tx.size() != 0) ? m_tx[0] : 8'h00;
      s.rxr   = rx_can;
      s.hlt   = m_halt;
      st_q.push_back(s);

      rd = 8'h00;
      if (!r) begin
         m_tx.delete();
         m_rx.delete();
         m_halt = 0;
      end else begin
         if (!io && !w)
            rd = m_mem.exists(idx) ? m_mem[idx] : 8'h00;
         else if (io && !w && off == 3'd0 && m_rx.size() > 0)
            rd = m_rx.pop_front();
         else if (io && !w && off == 3'd4)
            rd = {6'b0, m_tx.size() == D, m_rx.size() != 0};
         if (!io && w) m_mem[idx] = d;
         if (io && w && off == 3'd4) m_halt = 1;
         if (txr && m_tx.size() > 0) link_q.push_back(m_tx.pop_front());
         if (io && w && off == 3'd0 && !stall) m_tx.push_back(d);
         if (rxv && rx_can) m_rx.push_back(rxd);
      end
      rd_q.push_back(rd);
   endtask

   task automatic idle(input bit txr = 0);
      step(32'h0, 1'b0, 8'h00, txr);
   endtask

   // Monitor: status of the current cycle, read data of the previous request, link bytes.
   initial begin
      st_t s;
      forever begin
         @(negedge clk);
         if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("io_stall", bus.io_stall, s.stall);
            chk("tx_valid", bus.tx_valid, s.txv);
            chk("rx_ready", bus.rx_ready, s.rxr);
            chk("halted", bus.halted, s.hlt);
            if (s.txv) chk("tx_data", bus.tx_data, s.txd);
         end
         if (rd_q.size() > 1) chk("ram_loaded_data", bus.ram_loaded_data, rd_q.pop_front());
         if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            if (link_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_link: byte %0h consumed, none expected", bus.tx_data);
            end else begin
               chk("tx_link", bus.tx_data, link_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      bus.ram_addr = '0;
      bus.ram_writing = 1'b0;
      bus.ram_data = '0;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = '0;
      rd_q.push_back(8'h00);
      step(32'h0, 0, 8'h00, 0, 0, 8'h00, 0);

      // RAM write then read-back, plus a never-written byte
      step(32'h100, 1, 8'h5A);
      step(32'h100, 0, 8'h00);
      step(32'h101, 0, 8'h00);
      idle();

      // single tx byte held, then consumed
      step(IOB, 1, 8'h41);
      idle(0);
      idle(1);
      idle(0);

      // tx overflow: ninth write stalls until the link pops
      for (int i = 0; i < 9; i++) step(IOB, 1, 8'(i));
      step(IOB, 1, 8'h08, 1);
      for (int i = 0; i < 10; i++) idle(1);

      // rx path and status byte
      step(32'h0, 0, 8'h00, 0, 1, 8'h31);
      step(32'h0, 0, 8'h00, 0, 1, 8'h32);
      step(IOB, 0, 8'h00);
      step(IOB, 0, 8'h00);
      step(IOB, 0, 8'h00);
      step(IOB + 4, 0, 8'h00);
      step(32'h0, 0, 8'h00, 0, 1, 8'h77);
      step(IOB + 4, 0, 8'h00);
      step(IOB, 0, 8'h00);
      idle();

      // halt is sticky
      step(IOB + 4, 1, 8'hC3);
      idle();
      idle();

      // rx pointer wrap with interleaved reads
      for (int i = 0; i < 20; i++) begin
         step(32'h0, 0, 8'h00, 0, 1, 8'(8'h80 + i));
         if (i % 3 != 0) step(IOB, 0, 8'h00);
      end
      for (int i = 0; i < 10; i++) step(IOB, 0, 8'h00);

      // reset with tx bytes queued; RAM survives
      for (int i = 0; i < 3; i++) step(IOB, 1, 8'(8'hE0 + i));
      step(32'h0, 0, 8'h00, 0, 0, 8'h00, 0);
      step(32'h100, 0, 8'h00);
      idle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         bit r, txr, rxv;
         case ($urandom_range(0, 3))
            0:       a = 32'h100 + 32'($urandom_range(0, 15));
            1, 2:    a = IOB + 32'($urandom_range(0, 7));
            default: a = $urandom & 32'h0001_FFFF;
         endcase
         r   = $urandom_range(0, 249) != 0;
         txr = r && ($urandom_range(0, 2) == 0);
         rxv = r && ($urandom_range(0, 1) == 0);
         step(a, 1'($urandom_range(0, 1)), 8'($urandom), txr, rxv, 8'($urandom), r);
      end

      for (int i = 0; i < 12; i++) idle(1);
      @(negedge clk);
      #1;
      chk("link_drained", link_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
